notch_scheduler: RTL and testbench

Time-multiplexed controller that shares a single sequential notch-filter multiply-accumulate datapath between `NCH` 8-bit sample streams. It sits between the per-channel sample sources and the downstream sink. It arbitrates requesters round-robin and keeps per-channel delay-line state. It sequences the second-order notch difference equation one multiply per cycle and hosts the runtime-writable coefficient registers.

---
 rtl/notch_scheduler_if.sv | 28 ++
 rtl/notch_scheduler.sv | 169 ++++++++++++++++
 tb/tb_notch_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/notch_scheduler_if.sv
// Sample, result and coefficient-write bundle for notch_scheduler.
// The slave modport is the scheduler's view; master is the source/sink side.
interface notch_scheduler_if #(
  parameter int NCH = 2,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]   in_valid;
  logic [8*NCH-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [CW-1:0]    out_ch;
  logic             out_ready;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [15:0]      cfg_data;
  logic             cfg_ready;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, out_ch, cfg_ready
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, out_ch, cfg_ready
  );
endinterface

// File: rtl/notch_scheduler.sv
// Round-robin scheduler sharing one notch-filter MAC across NCH sample streams.
// Optional NOTCH_BYPASS_EN adds bypass_i, which forwards the raw sample unfiltered.
module notch_scheduler #(
  parameter int NCH = 2,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic clk,
  input  logic rst,
`ifdef NOTCH_BYPASS_EN
  input  logic bypass_i,
`endif
  notch_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, OUT} state_t;

  localparam logic signed [15:0] A1_RST  = 16'sd31130;
  localparam logic signed [15:0] RA1_RST = 16'sd29491;
  localparam logic signed [15:0] R2_RST  = 16'sd15401;

  state_t             state_q, state_d;
  logic [CW-1:0]      lastGrant_q, ch_q, grantIdx, grantCand;
  logic               grantValid, bypassHit;
  int                 rrIdx;
  logic signed [15:0] a1_q, ra1_q, r2_q;
  logic signed [15:0] x1_q [NCH];
  logic signed [15:0] x2_q [NCH];
  logic signed [15:0] y1_q [NCH];
  logic signed [15:0] y2_q [NCH];
  logic signed [15:0] x0_q, sampleX0, coef, opnd, y16;
  logic signed [31:0] acc_q, acc_d, product, prodShifted;
  logic [7:0]         sample, outData_q;
  logic [CW-1:0]      outCh_q;

`ifdef NOTCH_BYPASS_EN
  assign bypassHit = bypass_i;
`else
  assign bypassHit = 1'b0;
`endif

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    grantCand  = '0;
    rrIdx      = 0;
    for (int k = 1; k <= NCH; k++) begin
      rrIdx     = (int'(lastGrant_q) + k) % NCH;
      grantCand = CW'(rrIdx);
      if (!grantValid && bus.in_valid[grantCand]) begin
        grantValid = 1'b1;
        grantIdx   = grantCand;
      end
    end
  end

  assign sample   = bus.in_data[{grantIdx, 3'b000} +: 8];
  assign sampleX0 = {sample, 8'b0};

  always_comb begin
    coef = a1_q;
    opnd = x1_q[ch_q];
    case (state_q)
      MUL1: begin
        coef = ra1_q;
        opnd = y1_q[ch_q];
      end
      MUL2: begin
        coef = r2_q;
        opnd = y2_q[ch_q];
      end
      default: ;
    endcase
    product     = 32'(coef) * 32'(opnd);
    prodShifted = product >>> 14;

    acc_d = acc_q;
    case (state_q)
      IDLE:    acc_d = 32'(sampleX0) + 32'(x2_q[grantIdx]);
      MUL0:    acc_d = acc_q - prodShifted;
      MUL1:    acc_d = acc_q + prodShifted;
      MUL2:    acc_d = acc_q - prodShifted;
      default: ;
    endcase

    if (acc_d > 32'sd32767)
      y16 = 16'sh7FFF;
    else if (acc_d < -32'sd32768)
      y16 = 16'sh8000;
    else
      y16 = acc_d[15:0];
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = '0;
    bus.cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        if (grantValid) begin
          bus.in_ready[grantIdx] = 1'b1;
          state_d = bypassHit ? OUT : MUL0;
        end
      end
      MUL0:    state_d = MUL1;
      MUL1:    state_d = MUL2;
      MUL2:    state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Channel state commits in MUL2, so a stalled OUT never loses a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= CW'(NCH - 1);
      ch_q        <= '0;
      x0_q        <= '0;
      acc_q       <= '0;
      outData_q   <= '0;
      outCh_q     <= '0;
      a1_q        <= A1_RST;
      ra1_q       <= RA1_RST;
      r2_q        <= R2_RST;
      for (int i = 0; i < NCH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      if (bus.cfg_we && state_q == IDLE) begin
        case (bus.cfg_addr)
          2'd0:    a1_q  <= bus.cfg_data;
          2'd1:    ra1_q <= bus.cfg_data;
          2'd2:    r2_q  <= bus.cfg_data;
          default: ;
        endcase
      end
      if (state_q == IDLE && grantValid) begin
        lastGrant_q <= grantIdx;
        ch_q        <= grantIdx;
        x0_q        <= sampleX0;
        if (bypassHit) begin
          outData_q <= sample;
          outCh_q   <= grantIdx;
        end
      end
      if (state_q == MUL2) begin
        outData_q   <= y16[15:8];
        outCh_q     <= ch_q;
        x2_q[ch_q]  <= x1_q[ch_q];
        x1_q[ch_q]  <= x0_q;
        y2_q[ch_q]  <= y1_q[ch_q];
        y1_q[ch_q]  <= y16;
      end
    end
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = outData_q;
  assign bus.out_ch    = outCh_q;
endmodule

// File: tb/tb_notch_scheduler.sv
// Scoreboard bench for notch_scheduler: directed samples push hand-computed
// results into a queue that an independent monitor drains on each transfer.
`timescale 1ns/1ps
module tb_notch_scheduler;
  localparam int NCH = 2;
  localparam int CW  = 1;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         acceptCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;
  logic prevValid = 1'b0;
  exp_t expQ[$];
  logic [7:0] rrExp [4] = '{8'd64, 8'd32, 8'hF9, 8'hFC};

  notch_scheduler_if #(.NCH(NCH), .CW(CW)) bus ();

  notch_scheduler #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef NOTCH_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic applyStimulus(input int ch, input logic [7:0] data,
                               input logic [7:0] expData, input bit push,
                               output int acceptCycle);
    int n = 0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[8*ch +: 8] = data;
    #1;
    while (!bus.in_ready[ch] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) reportTimeout("accept");
    acceptCycle = cycleCount;
    if (push) expQ.push_back('{ch: ch, data: expData, acceptCycle: cycleCount});
    @(negedge clk);
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [15:0] data);
    int n = 0;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    while (!bus.cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) reportTimeout("cfg write");
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) reportTimeout("drain");
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = '0;
    bus.cfg_we = 1'b0;
    bus.out_ready = 1'b1;
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: latency on each rising out_valid, data/channel on each transfer.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        prevValid = 1'b0;
      end else begin
        if (bus.out_valid && !prevValid && expQ.size() != 0)
          checkOutput("latency", cycleCount - expQ[0].acceptCycle, 4);
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected output: ch=%0d data=0x%0h, none expected",
                     bus.out_ch, bus.out_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_data", bus.out_data, e.data);
            checkOutput("out_ch", bus.out_ch, e.ch);
          end
        end
        prevValid = bus.out_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c, n, g, grants;
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset in_ready", bus.in_ready, 0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_data", bus.out_data, 0);
    checkOutput("reset out_ch", bus.out_ch, 0);
    checkOutput("reset cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);

    $display("[TB] impulse");
    applyStimulus(0, 8'd64, 8'd64, 1'b1, c);
    applyStimulus(0, 8'd0, 8'hF9, 1'b1, c);
    waitDrain();

    $display("[TB] round-robin");
    doReset();
    bus.in_valid = 2'b11;
    bus.in_data = {8'd32, 8'd64};
    grants = 0;
    n = 0;
    while (grants < 4 && n < 100) begin
      #1;
      if (bus.in_ready != '0) begin
        g = bus.in_ready[1] ? 1 : 0;
        checkOutput("rr grant", g, grants % 2);
        checkOutput("rr onehot", $countones(bus.in_ready), 1);
        expQ.push_back('{ch: grants % 2, data: rrExp[grants], acceptCycle: cycleCount});
        grants++;
        @(negedge clk);
        if (grants <= 2) bus.in_data[8*g +: 8] = 8'd0;
        else bus.in_valid[g] = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    if (grants < 4) reportTimeout("rr grants");
    bus.in_valid = '0;
    waitDrain();

    $display("[TB] saturation");
    doReset();
    cfgWrite(2'd0, 16'd0);
    cfgWrite(2'd1, 16'd16384);
    applyStimulus(0, 8'd127, 8'd127, 1'b1, c);
    applyStimulus(0, 8'd127, 8'd127, 1'b1, c);
    applyStimulus(0, 8'h80, 8'h07, 1'b1, c);
    waitDrain();

    $display("[TB] backpressure");
    doReset();
    bus.out_ready = 1'b0;
    applyStimulus(0, 8'd64, 8'd64, 1'b1, c);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) reportTimeout("out_valid");
    bus.in_valid[1] = 1'b1;
    bus.in_data[15:8] = 8'd32;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("stall out_valid", bus.out_valid, 1);
      checkOutput("stall out_data", bus.out_data, 64);
      checkOutput("stall out_ch", bus.out_ch, 0);
      checkOutput("stall in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("release out_valid", bus.out_valid, 0);
    checkOutput("release in_ready", bus.in_ready, 2'b10);
    applyStimulus(1, 8'd32, 8'd32, 1'b1, c);
    waitDrain();

    $display("[TB] config gating");
    doReset();
    applyStimulus(0, 8'd64, 8'd64, 1'b1, c);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = 16'd0;
    #1;
    checkOutput("busy cfg_ready", bus.cfg_ready, 0);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    waitDrain();
    applyStimulus(0, 8'd0, 8'hF9, 1'b1, c);
    waitDrain();
    applyStimulus(0, 8'd0, 8'hF8, 1'b1, c);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd1;
    bus.cfg_data = 16'd0;
    n = 0;
    while (!bus.cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) reportTimeout("cfg accept");
    else checkOutput("cfg accept cycle", cycleCount - c, 5);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    waitDrain();

    $display("[TB] mid-op reset");
    doReset();
    cfgWrite(2'd0, 16'd0);
    applyStimulus(0, 8'd64, 8'd0, 1'b0, c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst in_ready", bus.in_ready, 0);
    checkOutput("midrst out_valid", bus.out_valid, 0);
    checkOutput("midrst out_data", bus.out_data, 0);
    checkOutput("midrst out_ch", bus.out_ch, 0);
    checkOutput("midrst cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    applyStimulus(0, 8'd64, 8'd64, 1'b1, c);
    applyStimulus(0, 8'd0, 8'hF9, 1'b1, c);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
